// File: rtl/join3_sync.sv
`default_nettype none
// ============================================================================
// Module   : join3_sync
// Purpose  : Clocked three-way join for 4-phase bundled-data handshakes.
//            Optional watchdog enabled by defining JOIN3_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module join3_sync #(
  parameter int WIDTH          = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_in1_i,
  input  logic               req_in2_i,
  input  logic               req_in3_i,
  input  logic [WIDTH-1:0]   data_in1_i,
  input  logic [WIDTH-1:0]   data_in2_i,
  input  logic [WIDTH-1:0]   data_in3_i,
  output logic               ack_in_o,
  output logic               req_out_o,
  input  logic               ack_out_i,
  output logic [3*WIDTH-1:0] data_out_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_OUT_REQ = 3'd1,
    S_OUT_REL = 3'd2,
    S_IN_ACK  = 3'd3,
    S_IN_REL  = 3'd4
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("join3_sync: illegal SYNC_STAGES or TIMEOUT_CYCLES");
  end

  // Stage 0 is the metastable-facing flop; the last stage feeds the FSM.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sync_in;
  logic [2:0]                  req_s;
  logic                        ack_s;

  assign sync_in = {ack_out_i, req_in3_i, req_in2_i, req_in1_i};
  assign req_s   = sync_q[SYNC_STAGES-1][2:0];
  assign ack_s   = sync_q[SYNC_STAGES-1][3];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sync_in};
    end
  end

  state_t             state_q;
  logic               req_out_q;
  logic               ack_in_q;
  logic [2:0]         arrived_q;
  logic [WIDTH-1:0]   cap1_q;
  logic [WIDTH-1:0]   cap2_q;
  logic [WIDTH-1:0]   cap3_q;
  logic [2:0]         take;
  logic               all_here;

  assign take     = (state_q == S_COLLECT) ? (req_s & ~arrived_q) : 3'b000;
  assign all_here = ((arrived_q | req_s) == 3'b111);

  // Capture registers only load in COLLECT, so data_out_o is frozen for the
  // whole output handshake without a separate holding register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_COLLECT;
      req_out_q <= 1'b0;
      ack_in_q  <= 1'b0;
      arrived_q <= 3'b000;
      cap1_q    <= '0;
      cap2_q    <= '0;
      cap3_q    <= '0;
    end else begin
      if (take[0]) cap1_q <= data_in1_i;
      if (take[1]) cap2_q <= data_in2_i;
      if (take[2]) cap3_q <= data_in3_i;
      arrived_q <= arrived_q | take;

      case (state_q)
        S_COLLECT: begin
          // A stale downstream ack holds us here until it is released.
          if (all_here && !ack_s) begin
            state_q   <= S_OUT_REQ;
            req_out_q <= 1'b1;
          end
        end
        S_OUT_REQ: begin
          if (ack_s) begin
            state_q   <= S_OUT_REL;
            req_out_q <= 1'b0;
          end
        end
        S_OUT_REL: begin
          if (!ack_s) begin
            state_q  <= S_IN_ACK;
            ack_in_q <= 1'b1;
          end
        end
        S_IN_ACK: begin
          if (req_s == 3'b000) begin
            state_q  <= S_IN_REL;
            ack_in_q <= 1'b0;
          end
        end
        S_IN_REL: begin
          state_q   <= S_COLLECT;
          arrived_q <= 3'b000;
        end
        default: begin
          state_q   <= S_COLLECT;
          req_out_q <= 1'b0;
          ack_in_q  <= 1'b0;
          arrived_q <= 3'b000;
        end
      endcase
    end
  end

  assign req_out_o  = req_out_q;
  assign ack_in_o   = ack_in_q;
  assign data_out_o = {cap3_q, cap2_q, cap1_q};

`ifdef JOIN3_TIMEOUT_EN
  localparam int              TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q;
  logic [TW-1:0] tmo_cnt_d;
  logic          err_q;

  // Counts only while a transaction is partially assembled; saturates at the limit.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != S_COLLECT || arrived_q == 3'b000) begin
      tmo_cnt_d = '0;
    end else if (arrived_q != 3'b111 && tmo_cnt_q != TLIM) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_cnt_d == TLIM) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_join3_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_join3_sync
// Purpose  : Directed self-checking bench for join3_sync (SYNC_STAGES=2).
// Revision : 1.0
// ============================================================================
module tb_join3_sync;
  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_in1_i, req_in2_i, req_in3_i;
  logic [W-1:0]   data_in1_i, data_in2_i, data_in3_i;
  logic           ack_in_o;
  logic           req_out_o;
  logic           ack_out_i;
  logic [3*W-1:0] data_out_o;
  logic           err_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int xfers    = 0;
  logic [3*W-1:0] exp_data;

  join3_sync #(
    .WIDTH(W),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_in1_i(req_in1_i),
    .req_in2_i(req_in2_i),
    .req_in3_i(req_in3_i),
    .data_in1_i(data_in1_i),
    .data_in2_i(data_in2_i),
    .data_in3_i(data_in3_i),
    .ack_in_o(ack_in_o),
    .req_out_o(req_out_o),
    .ack_out_i(ack_out_i),
    .data_out_o(data_out_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3*W-1:0] obs, input logic [3*W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sel 0 watches req_out_o, sel 1 watches ack_in_o.
  task automatic wait_sig(input int sel, input logic val, input int budget, input string tag);
    logic s;
    for (int i = 0; i < budget; i++) begin
      s = (sel == 0) ? req_out_o : ack_in_o;
      if (s === val) break;
      tick(1);
    end
    s = (sel == 0) ? req_out_o : ack_in_o;
    check(tag, {95'd0, s}, {95'd0, val});
  endtask

  task automatic finish_hs(input string tag);
    ack_out_i = 1'b1;
    wait_sig(0, 1'b0, 20, {tag, " req_out fall"});
    ack_out_i = 1'b0;
    wait_sig(1, 1'b1, 20, {tag, " ack_in rise"});
    req_in1_i = 1'b0;
    req_in2_i = 1'b0;
    req_in3_i = 1'b0;
    wait_sig(1, 1'b0, 20, {tag, " ack_in fall"});
    tick(1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_in1_i = 1'b0; req_in2_i = 1'b0; req_in3_i = 1'b0;
    data_in1_i = '0;  data_in2_i = '0;  data_in3_i = '0;
    ack_out_i = 1'b0;

    // ---- reset state and simultaneous arrival ----
    tick(2);
    check("rst req_out", {95'd0, req_out_o}, 96'd0);
    check("rst ack_in", {95'd0, ack_in_o}, 96'd0);
    check("rst data_out", data_out_o, 96'd0);
    check("rst err", {95'd0, err_o}, 96'd0);
    rst_i = 1'b0;
    data_in1_i = 32'h11; data_in2_i = 32'h22; data_in3_i = 32'h33;
    req_in1_i = 1'b1; req_in2_i = 1'b1; req_in3_i = 1'b1;
    tick(2);
    check("t1 req_out edge2", {95'd0, req_out_o}, 96'd0);
    tick(1);
    check("t1 req_out edge3", {95'd0, req_out_o}, 96'd1);
    check("t1 data", data_out_o, {32'h33, 32'h22, 32'h11});
    ack_out_i = 1'b1;
    tick(2);
    check("t1 req_out held", {95'd0, req_out_o}, 96'd1);
    tick(1);
    check("t1 req_out fall", {95'd0, req_out_o}, 96'd0);
    ack_out_i = 1'b0;
    tick(2);
    check("t1 ack_in early", {95'd0, ack_in_o}, 96'd0);
    tick(1);
    check("t1 ack_in rise", {95'd0, ack_in_o}, 96'd1);
    req_in1_i = 1'b0; req_in2_i = 1'b0; req_in3_i = 1'b0;
    tick(2);
    check("t1 ack_in held", {95'd0, ack_in_o}, 96'd1);
    tick(1);
    check("t1 ack_in fall", {95'd0, ack_in_o}, 96'd0);
    tick(1);
    check("t1 idle req_out", {95'd0, req_out_o}, 96'd0);

    // ---- staggered arrival, channel 1 drops early ----
    do_reset();
    req_in1_i = 1'b1; data_in1_i = 32'hA1;
    tick(10);
    check("t2 ch1 captured", {64'd0, data_out_o[31:0]}, {64'd0, 32'hA1});
    check("t2 partial req_out", {95'd0, req_out_o}, 96'd0);
    req_in1_i = 1'b0; data_in1_i = 32'hDEAD;
    req_in2_i = 1'b1; data_in2_i = 32'hB2;
    tick(15);
    req_in3_i = 1'b1; data_in3_i = 32'hC3;
    tick(2);
    check("t2 req_out edge2", {95'd0, req_out_o}, 96'd0);
    tick(1);
    check("t2 req_out edge3", {95'd0, req_out_o}, 96'd1);
    check("t2 data", data_out_o, {32'hC3, 32'hB2, 32'hA1});
    finish_hs("t2");

    // ---- stale downstream ack out of reset ----
    ack_out_i = 1'b1;
    data_in1_i = 32'h5; data_in2_i = 32'h6; data_in3_i = 32'h7;
    req_in1_i = 1'b1; req_in2_i = 1'b1; req_in3_i = 1'b1;
    do_reset();
    tick(10);
    check("t3 stale ack blocks", {95'd0, req_out_o}, 96'd0);
    check("t3 data captured", data_out_o, {32'h7, 32'h6, 32'h5});
    ack_out_i = 1'b0;
    tick(2);
    check("t3 req_out edge2", {95'd0, req_out_o}, 96'd0);
    tick(1);
    check("t3 req_out edge3", {95'd0, req_out_o}, 96'd1);

    // ---- asynchronous reset during OUT_REQ ----
    #3 rst_i = 1'b1;
    #1;
    check("t4 async req_out", {95'd0, req_out_o}, 96'd0);
    check("t4 async ack_in", {95'd0, ack_in_o}, 96'd0);
    check("t4 async data", data_out_o, 96'd0);
    check("t4 async err", {95'd0, err_o}, 96'd0);
    tick(1);
    rst_i = 1'b0;
    tick(2);
    check("t4 restart edge2", {95'd0, req_out_o}, 96'd0);
    tick(1);
    check("t4 restart edge3", {95'd0, req_out_o}, 96'd1);
    check("t4 restart data", data_out_o, {32'h7, 32'h6, 32'h5});
    finish_hs("t4");

    // ---- watchdog: only channel 1 arrives ----
    do_reset();
    req_in1_i = 1'b1; data_in1_i = 32'h99;
    tick(10);
    check("t5 err before limit", {95'd0, err_o}, 96'd0);
    tick(30);
`ifdef JOIN3_TIMEOUT_EN
    check("t5 err set", {95'd0, err_o}, 96'd1);
    req_in1_i = 1'b0;
    tick(10);
    check("t5 err sticky", {95'd0, err_o}, 96'd1);
`else
    check("t5 err tied low", {95'd0, err_o}, 96'd0);
    req_in1_i = 1'b0;
    tick(10);
    check("t5 err still low", {95'd0, err_o}, 96'd0);
`endif
    do_reset();
    check("t5 err cleared", {95'd0, err_o}, 96'd0);

    // ---- ten back-to-back transactions ----
    for (int k = 0; k < 10; k++) begin
      data_in1_i = 32'h1000 + 32'(k);
      data_in2_i = 32'h2000 + 32'(k);
      data_in3_i = 32'h3000 + 32'(k);
      exp_data = {32'h3000 + 32'(k), 32'h2000 + 32'(k), 32'h1000 + 32'(k)};
      req_in1_i = 1'b1; req_in2_i = 1'b1; req_in3_i = 1'b1;
      wait_sig(0, 1'b1, 20, "t6 req_out rise");
      if (req_out_o === 1'b1) xfers++;
      check("t6 data", data_out_o, exp_data);
      data_in1_i = ~data_in1_i; data_in2_i = ~data_in2_i; data_in3_i = ~data_in3_i;
      ack_out_i = 1'b1;
      for (int c = 0; c < 10 && req_out_o === 1'b1; c++) begin
        check("t6 data stable", data_out_o, exp_data);
        tick(1);
      end
      check("t6 req_out fall", {95'd0, req_out_o}, 96'd0);
      ack_out_i = 1'b0;
      wait_sig(1, 1'b1, 20, "t6 ack_in rise");
      req_in1_i = 1'b0; req_in2_i = 1'b0; req_in3_i = 1'b0;
      wait_sig(1, 1'b0, 20, "t6 ack_in fall");
      tick(1);
    end
    check("t6 transfer count", 96'(xfers), 96'd10);
    tick(10);
    check("t6 no extra req_out", {95'd0, req_out_o}, 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/join3_sync.md
Name: join3_sync

Overview:
- Clocked join for the 4-phase bundled-data handshake.
- Merges three upstream request/data channels into one downstream channel. It is the converging counterpart of the three-way fork: the fork drives three reqs and C-element-joins their acks, while this block joins three reqs and drives one ack back to all three sources.
- Sits at the boundary where asynchronous pipeline branches re-enter the clocked domain.
- All handshake inputs are synchronised; data is captured under the bundled-data rule.

Parameters:
- WIDTH, 32, data width of each channel.
- SYNC_STAGES, 2, flip-flop synchroniser depth on every req/ack input (legal range 2..4).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when JOIN3_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_in1_i  in  1  channel 1 request.
- req_in2_i  in  1  channel 2 request.
- req_in3_i  in  1  channel 3 request.
- data_in1_i  in  WIDTH  channel 1 data, stable while req_in1_i is high.
- data_in2_i  in  WIDTH  channel 2 data, stable while req_in2_i is high.
- data_in3_i  in  WIDTH  channel 3 data, stable while req_in3_i is high.
- ack_in_o  out  1  common acknowledge to all three upstream channels.
- req_out_o  out  1  downstream request.
- ack_out_i  in  1  downstream acknowledge.
- data_out_o  out  3*WIDTH  joined data {ch3, ch2, ch1}, valid while req_out_o is high.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Synchronisers: req_inN_i and ack_out_i each pass through SYNC_STAGES flops, reset to 0; the synchronised versions are req_sN and ack_s. All FSM decisions use synchronised values only.
- Arrival tracking:
  - arrived[3:1] flags are sticky.
  - In COLLECT, on the first cycle req_sN==1: set arrived[N] and capture data_inN_i into its register.
  - Each channel's data is captured once per transaction.
  - A later req drop in COLLECT does not clear the flag or the data (tolerates early-dropping sources; logged as no error).
- FSM states, registered outputs:
  - COLLECT: req_out_o=0, ack_in_o=0. Go to OUT_REQ when (arrived | req_s)==3'b111 and ack_s==0. If ack_s==1 (stale ack), stay.
  - OUT_REQ: req_out_o=1. Go to OUT_REL when ack_s==1.
  - OUT_REL: req_out_o=0. Go to IN_ACK when ack_s==0.
  - IN_ACK: ack_in_o=1. Go to IN_REL when req_s1==req_s2==req_s3==0.
  - IN_REL: ack_in_o=0; clear arrived; go to COLLECT next cycle.
- Data output:
  - data_out_o is driven from the capture registers, frozen from entry to OUT_REQ until IN_REL.
  - data_out_o is never changed while req_out_o==1.
- Latency (clk edges):
  - Last req_inN_i sampled high -> req_out_o high: SYNC_STAGES+1.
  - ack_out_i high -> req_out_o low: SYNC_STAGES+1.
  - ack_out_i low -> ack_in_o high: SYNC_STAGES+1.
  - All reqs low -> ack_in_o low: SYNC_STAGES+1.
  - Minimum full cycle with an ideal environment: 4*(SYNC_STAGES+1)+1.
- Simultaneous events:
  - All three reqs arriving on the same edge behaves identically to staggered arrival.
  - An ack_s rise coincident with entry to OUT_REQ is acted on in the next cycle.
- Reset (asserted at any time, including mid-transaction):
  - req_out_o=0, ack_in_o=0, data_out_o=0, err_o=0.
  - arrived=0, synchronisers=0, state=COLLECT.
  - A handshake in flight is abandoned; the environment must also reset.
- Protocol violations:
  - ack_out_i falling before req_out_o falls is ignored until OUT_REL.
  - A req re-raised in IN_ACK is not observed until COLLECT.

Optional Feature:
JOIN3_TIMEOUT_EN
- Defined:
  - A counter of ceil(log2(TIMEOUT_CYCLES+1)) bits runs in COLLECT while arrived is neither 0 nor 3'b111. It clears on leaving COLLECT or when arrived==0.
  - Reaching TIMEOUT_CYCLES sets err_o=1.
  - err_o stays set until rst_i; the FSM is unaffected.
- Undefined: no counter logic; err_o tied to 0.

Test Plan:
- Reset, then req_in1/2/3 rise on the same edge with data 0x11, 0x22, 0x33 (SYNC_STAGES=2) -> req_out_o rises 3 edges later with data_out_o=0x00000033_00000022_00000011. Complete the handshake -> ack_in_o pulses; the FSM returns to COLLECT.
- Staggered reqs at cycles 0, 10, 25 -> req_out_o rises at cycle 28; data_out_o holds each channel's value captured at its own arrival.
- ack_out_i held high coming out of reset, all reqs high -> req_out_o stays 0 until ack_out_i drops, then rises 3 edges after ack_s==0.
- Assert rst_i while in OUT_REQ with req_out_o=1 -> all outputs 0 on the same edge. After release with all reqs still high -> a new transaction starts and req_out_o rises 3 edges later.
- With JOIN3_TIMEOUT_EN and TIMEOUT_CYCLES=16, only req_in1_i raised -> err_o=1 after 16 cycles in COLLECT, sticky. Without the macro -> err_o stays 0.
- Ten back-to-back transactions with incrementing data -> no lost or duplicated transfer; data_out_o is stable throughout every req_out_o high phase.
